fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter N, default 64, giving the PC and branch-target width.
REQ-002 The block SHALL have parameter IW, default 32, giving the instruction width.
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-005 The block SHALL have port stall_F, input, 1 bit: hold PC and the IF/ID register.
REQ-006 The block SHALL have port flush_D, input, 1 bit: replace the IF/ID contents with a bubble.
REQ-007 The block SHALL have port pcsrc, input, 1 bit: taken-branch redirect request.
REQ-008 The block SHALL have port branch_target, input, N bits: redirect byte address.
REQ-009 The block SHALL have port imem_addr, output, 8 bits: word index to instruction memory.
REQ-010 The block SHALL have port imem_q, input, IW bits: combinational instruction-memory read data.
REQ-011 The block SHALL have port pc_F, output, N bits: current fetch PC (byte address).
REQ-012 The block SHALL have port instr_D, output, IW bits: IF/ID instruction.
REQ-013 The block SHALL have port pc_D, output, N bits: IF/ID PC.
REQ-014 The block SHALL have port valid_D, output, 1 bit: instr_D is a real fetched instruction.
REQ-015 The block SHALL have port halted, output, 1 bit: end of program reached.

Function
REQ-016 imem_addr SHALL equal pc_F[9:2] combinationally; memory read latency is zero cycles.
REQ-017 The state machine SHALL have the states RUN and HALT.
REQ-018 In RUN, with no stall, redirect or halt condition, each cycle SHALL apply: pc_F <= pc_F+4, instr_D <= imem_q, pc_D <= pc_F, valid_D <= 1.
REQ-019 The halt condition SHALL be: imem_q == 0, or pc_F[N-1:10] != 0 (PC outside the 256-word window).
REQ-020 On the halt condition in RUN, the block SHALL enter HALT, hold pc_F, load IF/ID with the bubble, and assert halted from the next cycle.
REQ-021 Bubble definition: instr_D = 32'h8b1f03ff (ADD XZR,XZR,XZR); valid_D = 0; pc_D = 0.
REQ-022 In HALT, pc_F SHALL hold, the IF/ID register SHALL load the bubble every cycle, and halted SHALL be 1.
REQ-023 pcsrc=1 SHALL set pc_F <= {branch_target[N-1:2],2'b00} and load the bubble into IF/ID, in any state; from HALT the state SHALL return to RUN.
REQ-024 stall_F=1 (and pcsrc=0) SHALL hold pc_F, instr_D, pc_D, valid_D and the state unchanged.
REQ-025 flush_D=1 SHALL load the bubble into IF/ID; pc_F SHALL still advance unless stall_F=1 or the block is in HALT.
REQ-026 Priority SHALL be: reset > pcsrc > stall_F > halt condition > flush_D > normal advance.
REQ-027 For stall_F=1 and flush_D=1 together (pcsrc=0), stall SHALL win for the PC and flush SHALL win for IF/ID.
REQ-028 PC arithmetic SHALL be modulo 2^N; wrap-around past the 10-bit window SHALL be caught by REQ-019.

Reset
REQ-029 On reset the outputs SHALL be: pc_F=0, pc_D=0, instr_D=32'h8b1f03ff, valid_D=0, halted=0, state=RUN.
REQ-030 Reset asserted mid-stall, mid-redirect or in HALT SHALL override all other inputs in that cycle.
REQ-031 The first fetch after reset deassertion SHALL come from address 0.

Structure
REQ-032 Package fetch_pkg SHALL hold the state enum, the NOP constant 32'h8b1f03ff, IMEM_WORDS=256, and PC_STEP=4.
REQ-033 The IF/ID register SHALL be one sub-module, flopre (a flop with synchronous reset, enable and a clear-to-bubble input), instantiated for {instr, pc, valid}.
REQ-034 The PC register and the FSM SHALL live in fetch_unit.

Verification
REQ-035 Bench scenario, sequential run: the memory returns f8000001, f8008002, f8000203 at words 0..2 → pc_F is 0, 4, 8, 12, and instr_D lags it by one cycle with valid_D=1.
REQ-036 Bench scenario, stall: stall_F=1 for 2 cycles at pc_F=8 → pc_F stays 8, instr_D holds f8008002, then the run resumes at 12.
REQ-037 Bench scenario, redirect: pcsrc=1 with branch_target=0x2B at pc_F=0x10 → next pc_F=0x28, one bubble, then instr_D = word 10.
REQ-038 Bench scenario, halt: the memory returns 0 at word 171 → halted=1 one cycle after pc_F=0x2AC, pc_F frozen, instr_D=8b1f03ff; a later pcsrc to 0 returns the block to RUN.
REQ-039 Bench scenario, simultaneous events: stall_F=1, flush_D=1 and pcsrc=1 in one cycle → the redirect is taken; then reset asserted in HALT → all REQ-029 values on the next edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;
   typedef enum logic {RUN, HALT} state_t;
   localparam logic [31:0] NOP = 32'h8b1f03ff;
   localparam int IMEM_WORDS = 256;
   localparam int PC_STEP = 4;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory read port between fetch stage and memory
interface fetch_unit_if #(parameter int IW = 32);
   logic [7:0]    imem_addr;
   logic [IW-1:0] imem_q;
   modport master (output imem_addr, input imem_q);
   modport slave (input imem_addr, output imem_q);
endinterface

// File: rtl/fetch_unit_flopre.sv
// flopre: register with sync reset, enable and clear-to-bubble; clear beats enable
module flopre #(
   parameter int W = 1,
   parameter logic [W-1:0] BUB = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk)
      if (reset || clr) q <= BUB;
      else if (en) q <= d;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, RUN/HALT control and IF/ID pipeline register
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int N  = 64,
   parameter int IW = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_F,
   input  logic              flush_D,
   input  logic              pcsrc,
   input  logic [N-1:0]      branch_target,
   fetch_unit_if.master      imem,
   output logic [N-1:0]      pc_F,
   output logic [IW-1:0]     instr_D,
   output logic [N-1:0]      pc_D,
   output logic              valid_D,
   output logic              halted
);
   localparam int WB = $clog2(IMEM_WORDS) + 2;
   localparam int W  = IW + N + 1;
   state_t state;
   logic   halt_cond;
   logic   clr;
   // any PC bit above the memory window means we ran off the program
   assign halt_cond = (imem.imem_q == '0) || (pc_F[N-1:WB] != '0);
   assign imem.imem_addr = pc_F[WB-1:2];
   assign clr = pcsrc || flush_D || (!stall_F && (state == HALT || halt_cond));
   always_ff @(posedge clk)
      if (reset) begin
         state  <= RUN;
         pc_F   <= '0;
         halted <= 1'b0;
      end else if (pcsrc) begin
         state  <= RUN;
         pc_F   <= branch_target & ~N'(3);
         halted <= 1'b0;
      end else if (!stall_F && state == RUN) begin
         if (halt_cond) begin
            state  <= HALT;
            halted <= 1'b1;
         end else pc_F <= pc_F + N'(PC_STEP);
      end
   flopre #(.W(W), .BUB({IW'(NOP), {N{1'b0}}, 1'b0})) u_ifid (
      .clk  (clk),
      .reset(reset),
      .en   (!stall_F),
      .clr  (clr),
      .d    ({imem.imem_q, pc_F, 1'b1}),
      .q    ({instr_D, pc_D, valid_D})
   );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit
module tb_fetch_unit;
   localparam int N = 64;
   localparam int IW = 32;
   localparam logic [31:0] BUBBLE = 32'h8b1f03ff;
   typedef struct {
      string       name;
      int          cyc;
      logic [N-1:0] pc;
      logic [31:0] instr;
      logic [N-1:0] pcd;
      logic        v;
      logic        h;
   } exp_t;
   logic clk = 0, reset = 1, stall_F = 0, flush_D = 0, pcsrc = 0;
   logic [N-1:0] branch_target = '0;
   logic [N-1:0] pc_F, pc_D;
   logic [IW-1:0] instr_D;
   logic valid_D, halted;
   logic [31:0] mem [256];
   int cyc = 0, tests = 0, fails = 0;
   exp_t q[$];
   fetch_unit_if #(.IW(IW)) bus ();
   assign bus.imem_q = mem[bus.imem_addr];
   fetch_unit #(.N(N), .IW(IW)) dut (
      .clk(clk), .reset(reset), .stall_F(stall_F), .flush_D(flush_D),
      .pcsrc(pcsrc), .branch_target(branch_target), .imem(bus),
      .pc_F(pc_F), .instr_D(instr_D), .pc_D(pc_D), .valid_D(valid_D), .halted(halted)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         e = q.pop_front();
         tests++;
         if (pc_F !== e.pc || instr_D !== e.instr || pc_D !== e.pcd || valid_D !== e.v ||
             halted !== e.h || bus.imem_addr !== e.pc[9:2]) begin
            fails++;
            $display("FAIL %s: got pc_F=%h instr_D=%h pc_D=%h valid_D=%b halted=%b imem_addr=%h, want pc_F=%h instr_D=%h pc_D=%h valid_D=%b halted=%b imem_addr=%h",
                     e.name, pc_F, instr_D, pc_D, valid_D, halted, bus.imem_addr,
                     e.pc, e.instr, e.pcd, e.v, e.h, e.pc[9:2]);
         end
      end
   task automatic step(input string name, input logic r, input logic s, input logic f,
                       input logic p, input logic [N-1:0] bt, input logic [N-1:0] pc,
                       input logic [31:0] instr, input logic [N-1:0] pcd,
                       input logic v, input logic h);
      exp_t e;
      reset = r; stall_F = s; flush_D = f; pcsrc = p; branch_target = bt;
      e.name = name; e.cyc = cyc + 1; e.pc = pc; e.instr = instr; e.pcd = pcd; e.v = v; e.h = h;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h91000000 | 32'(i);
      mem[0] = 32'hf8000001; mem[1] = 32'hf8008002; mem[2] = 32'hf8000203; mem[171] = 32'h0;
      @(posedge clk); #1;
      step("reset0", 1, 0, 0, 0, 0, 0, BUBBLE, 0, 0, 0);
      step("reset1", 1, 1, 1, 0, 0, 0, BUBBLE, 0, 0, 0);
      step("seq0", 0, 0, 0, 0, 0, 4, 32'hf8000001, 0, 1, 0);
      step("seq1", 0, 0, 0, 0, 0, 8, 32'hf8008002, 4, 1, 0);
      step("stall0", 0, 1, 0, 0, 0, 8, 32'hf8008002, 4, 1, 0);
      step("stall1", 0, 1, 0, 0, 0, 8, 32'hf8008002, 4, 1, 0);
      step("resume", 0, 0, 0, 0, 0, 12, 32'hf8000203, 8, 1, 0);
      step("seq3", 0, 0, 0, 0, 0, 16, 32'h91000003, 12, 1, 0);
      step("redirect", 0, 0, 0, 1, 64'h2b, 64'h28, BUBBLE, 0, 0, 0);
      step("word10", 0, 0, 0, 0, 0, 64'h2c, 32'h9100000a, 64'h28, 1, 0);
      step("flush", 0, 0, 1, 0, 0, 64'h30, BUBBLE, 0, 0, 0);
      step("stall_flush", 0, 1, 1, 0, 0, 64'h30, BUBBLE, 0, 0, 0);
      step("jmp2a0", 0, 0, 0, 1, 64'h2a0, 64'h2a0, BUBBLE, 0, 0, 0);
      step("w168", 0, 0, 0, 0, 0, 64'h2a4, 32'h910000a8, 64'h2a0, 1, 0);
      step("w169", 0, 0, 0, 0, 0, 64'h2a8, 32'h910000a9, 64'h2a4, 1, 0);
      step("w170", 0, 0, 0, 0, 0, 64'h2ac, 32'h910000aa, 64'h2a8, 1, 0);
      step("halt", 0, 0, 0, 0, 0, 64'h2ac, BUBBLE, 0, 0, 1);
      step("halt_hold", 0, 0, 0, 0, 0, 64'h2ac, BUBBLE, 0, 0, 1);
      step("halt_flush", 0, 0, 1, 0, 0, 64'h2ac, BUBBLE, 0, 0, 1);
      step("unhalt", 0, 0, 0, 1, 0, 0, BUBBLE, 0, 0, 0);
      step("rerun", 0, 0, 0, 0, 0, 4, 32'hf8000001, 0, 1, 0);
      step("all_three", 0, 1, 1, 1, 64'h40, 64'h40, BUBBLE, 0, 0, 0);
      step("jmp400", 0, 0, 0, 1, 64'h400, 64'h400, BUBBLE, 0, 0, 0);
      step("window_halt", 0, 0, 0, 0, 0, 64'h400, BUBBLE, 0, 0, 1);
      step("jmp_top", 0, 0, 0, 1, 64'hffff_ffff_ffff_ffff, 64'hffff_ffff_ffff_fffc, BUBBLE, 0, 0, 0);
      step("top_halt", 0, 0, 0, 0, 0, 64'hffff_ffff_ffff_fffc, BUBBLE, 0, 0, 1);
      step("reset_halt", 1, 1, 1, 1, 64'h80, 0, BUBBLE, 0, 0, 0);
      step("post_reset", 0, 0, 0, 0, 0, 4, 32'hf8000001, 0, 1, 0);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         fails++;
         $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
